sn76489_vgm_player: RTL and testbench

SN76489_VGM_PLAYER -- requirements
Module: sn76489_vgm_player

---
 rtl/sn76489_vgm_player_if.sv | 29 ++
 rtl/sn76489_vgm_player.sv | 169 ++++++++++++++++
 tb/tb_sn76489_vgm_player.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn76489_vgm_player_if.sv
`default_nettype none
// ============================================================================
// Module   : sn76489_vgm_player_if
// Brief    : VGM byte-stream handshake plus SN76489 write/status bundle
// Revision : 1.0
// ============================================================================
interface sn76489_vgm_player_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       in_restart;
    logic [3:0] out_reg;
    logic [7:0] out_val;
    logic       out_wr;
    logic       out_busy;
    logic       out_done;
    logic       out_err;

    modport master (
        output in_data, in_valid, in_restart,
        input  out_ready, out_reg, out_val, out_wr, out_busy, out_done, out_err
    );

    modport slave (
        input  in_data, in_valid, in_restart,
        output out_ready, out_reg, out_val, out_wr, out_busy, out_done, out_err
    );
endinterface
`default_nettype wire

// File: rtl/sn76489_vgm_player.sv
`default_nettype none
// ============================================================================
// Module   : sn76489_vgm_player
// Brief    : VGM command decoder issuing SN76489 register writes and waits
// Revision : 1.0
// ============================================================================
module sn76489_vgm_player #(
    parameter int SAMPLE_DIV = 567
) (
    input wire                  in_clk,
    input wire                  in_rst,
    sn76489_vgm_player_if.slave bus
);

    localparam logic [9:0] C_DIV_RELOAD = 10'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_ARG1  = 3'd1,
        S_ARG2  = 3'd2,
        S_WRITE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        wait_cmd_q, wait_cmd_d;
    logic [2:0]  latch_q, latch_d;
    logic [7:0]  cnt_lo_q, cnt_lo_d;
    logic [9:0]  div_q, div_d;
    logic [15:0] samp_q, samp_d;
    logic [3:0]  reg_q, reg_d;
    logic [7:0]  val_q, val_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        ready;
    logic        take;
    logic [15:0] arg_count;

    assign ready     = (state_q == S_FETCH) || (state_q == S_ARG1) || (state_q == S_ARG2);
    assign take      = ready && bus.in_valid;
    assign arg_count = {bus.in_data, cnt_lo_q};

    always_comb begin
        state_d    = state_q;
        wait_cmd_d = wait_cmd_q;
        latch_d    = latch_q;
        cnt_lo_d   = cnt_lo_q;
        div_d      = div_q;
        samp_d     = samp_q;
        reg_d      = reg_q;
        val_d      = val_q;

        case (state_q)
            S_FETCH: begin
                if (take) begin
                    casez (bus.in_data)
                        8'h50: begin state_d = S_ARG1; wait_cmd_d = 1'b0; end
                        8'h61: begin state_d = S_ARG1; wait_cmd_d = 1'b1; end
                        8'h62: begin state_d = S_WAIT; div_d = C_DIV_RELOAD; samp_d = 16'd735; end
                        8'h63: begin state_d = S_WAIT; div_d = C_DIV_RELOAD; samp_d = 16'd882; end
                        8'h66: state_d = S_DONE;
                        8'b0111_????: begin
                            state_d = S_WAIT;
                            div_d   = C_DIV_RELOAD;
                            samp_d  = 16'(bus.in_data[3:0]) + 16'd1;
                        end
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_ARG1: begin
                if (take) begin
                    if (wait_cmd_q) begin
                        cnt_lo_d = bus.in_data;
                        state_d  = S_ARG2;
                    end else begin
                        // A latch byte updates the register index before it is used.
                        if (bus.in_data[7]) begin
                            latch_d = bus.in_data[6:4];
                        end
                        reg_d   = {1'b0, (bus.in_data[7] ? bus.in_data[6:4] : latch_q)};
                        val_d   = bus.in_data;
                        state_d = S_WRITE;
                    end
                end
            end
            S_ARG2: begin
                if (take) begin
                    if (arg_count == 16'd0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WAIT;
                        div_d   = C_DIV_RELOAD;
                        samp_d  = arg_count;
                    end
                end
            end
            S_WRITE: state_d = S_FETCH;
            S_WAIT: begin
                if (div_q == 10'd0) begin
                    div_d  = C_DIV_RELOAD;
                    samp_d = samp_q - 16'd1;
                    if (samp_q == 16'd1) begin
                        state_d = S_FETCH;
                    end
                end else begin
                    div_d = div_q - 10'd1;
                end
            end
            S_DONE, S_ERR: begin
                if (bus.in_restart) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Status flags follow the next state so they line up with the state register.
        wr_d   = (state_d == S_WRITE);
        busy_d = (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= S_FETCH;
            wait_cmd_q <= 1'b0;
            latch_q    <= 3'd0;
            cnt_lo_q   <= 8'd0;
            div_q      <= 10'd0;
            samp_q     <= 16'd0;
            reg_q      <= 4'd0;
            val_q      <= 8'd0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cmd_q <= wait_cmd_d;
            latch_q    <= latch_d;
            cnt_lo_q   <= cnt_lo_d;
            div_q      <= div_d;
            samp_q     <= samp_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.out_ready = ready;
    assign bus.out_reg   = reg_q;
    assign bus.out_val   = val_q;
    assign bus.out_wr    = wr_q;
    assign bus.out_busy  = busy_q;
    assign bus.out_done  = done_q;
    assign bus.out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sn76489_vgm_player.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sn76489_vgm_player
// Brief    : Scoreboard bench for sn76489_vgm_player at SAMPLE_DIV 4 and 2
// Revision : 1.0
// ============================================================================
module tb_sn76489_vgm_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       drv_restart;
    logic       sel;
    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    logic [2:0] model_latch;

    typedef struct {
        logic [3:0] r;
        logic [7:0] v;
        int         at;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sn76489_vgm_player_if bus4();
    sn76489_vgm_player_if bus2();

    assign bus4.in_data    = drv_data;
    assign bus4.in_valid   = drv_valid;
    assign bus4.in_restart = drv_restart;
    assign bus2.in_data    = drv_data;
    assign bus2.in_valid   = drv_valid;
    assign bus2.in_restart = drv_restart;

    sn76489_vgm_player #(.SAMPLE_DIV(4)) dut4 (.in_clk(clk), .in_rst(rst_n), .bus(bus4.slave));
    sn76489_vgm_player #(.SAMPLE_DIV(2)) dut2 (.in_clk(clk), .in_rst(rst_n), .bus(bus2.slave));

    logic       obs_ready, obs_wr, obs_busy, obs_done, obs_err;
    logic [3:0] obs_reg;
    logic [7:0] obs_val;
    assign obs_ready = sel ? bus2.out_ready : bus4.out_ready;
    assign obs_wr    = sel ? bus2.out_wr    : bus4.out_wr;
    assign obs_busy  = sel ? bus2.out_busy  : bus4.out_busy;
    assign obs_done  = sel ? bus2.out_done  : bus4.out_done;
    assign obs_err   = sel ? bus2.out_err   : bus4.out_err;
    assign obs_reg   = sel ? bus2.out_reg   : bus4.out_reg;
    assign obs_val   = sel ? bus2.out_val   : bus4.out_val;

    // Every strobe must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && obs_wr === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL spurious_write: got reg=%0d val=%02h at cycle %0d, required no write",
                         obs_reg, obs_val, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (obs_reg !== mon_e.r || obs_val !== mon_e.v || cyc !== mon_e.at)
                    $display("FAIL write: got reg=%0d val=%02h cycle=%0d, required reg=%0d val=%02h cycle=%0d",
                             obs_reg, obs_val, cyc, mon_e.r, mon_e.v, mon_e.at);
                else
                    passed++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        drv_valid   = 1'b0;
        drv_restart = 1'b0;
        model_latch = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit exp_wr);
        int  n = 0;
        wr_t e;
        @(negedge clk);
        drv_data  = b;
        drv_valid = 1'b1;
        while (obs_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (obs_ready !== 1'b1) begin
            total++;
            $display("FAIL send_timeout: byte %02h ready=%b, required 1", b, obs_ready);
        end else if (exp_wr) begin
            if (b[7]) model_latch = b[6:4];
            e.r  = {1'b0, model_latch};
            e.v  = b;
            e.at = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (obs_busy === 1'b1 && n < 70000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        drv_restart = 1'b1;
        @(negedge clk);
        drv_restart = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        idle(3);
        total++;
        if (sb.size() != 0)
            $display("FAIL %s_pending: got %0d writes outstanding, required 0", name, sb.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        @(negedge clk);
        total++;
        if ({obs_reg, obs_val, obs_wr, obs_busy, obs_done, obs_err} !== 16'd0)
            $display("FAIL reset_outputs: got reg=%0d val=%02h wr=%b busy=%b done=%b err=%b, required all 0",
                     obs_reg, obs_val, obs_wr, obs_busy, obs_done, obs_err);
        else
            passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", obs_ready);
        else passed++;
    endtask

    task automatic test_writes();
        sel = 1'b0;
        do_reset();
        send(8'h50, 0); send(8'h9F, 1);
        send(8'h50, 0); send(8'h05, 1);
        send(8'h50, 0); send(8'h1A, 1);
        idle(2);
        total++;
        if (obs_reg !== 4'd1 || obs_val !== 8'h1A)
            $display("FAIL write_hold: got reg=%0d val=%02h, required reg=1 val=1a", obs_reg, obs_val);
        else
            passed++;
        check_sb_empty("writes");
    endtask

    task automatic test_wait_cmd();
        int n;
        sel = 1'b0;
        do_reset();
        send(8'h61, 0); send(8'h03, 0); send(8'h00, 0);
        measure_busy(n);
        total++;
        if (n != 12) $display("FAIL wait_61_3: got %0d busy cycles, required 12", n);
        else passed++;
        send(8'h50, 0); send(8'h80, 1);
        send(8'h61, 0); send(8'h00, 0); send(8'h00, 0);
        measure_busy(n);
        total++;
        if (n != 0 || obs_ready !== 1'b1)
            $display("FAIL wait_61_0: got %0d busy cycles ready=%b, required 0 and ready=1", n, obs_ready);
        else
            passed++;
        check_sb_empty("wait_cmd");
    endtask

    task automatic test_long_waits();
        int n;
        logic [7:0] cmds [4];
        int         exp  [4];
        cmds = '{8'h7F, 8'h62, 8'h63, 8'h70};
        exp  = '{32, 1470, 1764, 2};
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(cmds[i], 0);
            measure_busy(n);
            total++;
            if (n != exp[i]) $display("FAIL wait_%02h: got %0d busy cycles, required %0d", cmds[i], n, exp[i]);
            else passed++;
        end
        sel = 1'b0;
    endtask

    task automatic test_gapped();
        bit stall_ok = 1'b1;
        sel = 1'b0;
        do_reset();
        send(8'h50, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_err !== 1'b0)
                stall_ok = 1'b0;
        end
        total++;
        if (!stall_ok) $display("FAIL gap_stall: got state change during gap, required ready=1 idle");
        else passed++;
        send(8'hC3, 1);
        check_sb_empty("gapped");
    endtask

    task automatic test_done_restart();
        bit held = 1'b1;
        sel = 1'b0;
        do_reset();
        pulse_restart();
        total++;
        if (obs_ready !== 1'b1 || obs_done !== 1'b0)
            $display("FAIL restart_ignored: got ready=%b done=%b, required 1 0", obs_ready, obs_done);
        else
            passed++;
        send(8'h50, 0); send(8'hA5, 1);
        send(8'h66, 0);
        total++;
        if (obs_done !== 1'b1 || obs_ready !== 1'b0)
            $display("FAIL done_enter: got done=%b ready=%b, required 1 0", obs_done, obs_ready);
        else
            passed++;
        drv_valid = 1'b1;
        drv_data  = 8'h50;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) drv_data = 8'h90;
            if (obs_done !== 1'b1 || obs_ready !== 1'b0) held = 1'b0;
        end
        drv_valid = 1'b0;
        total++;
        if (!held) $display("FAIL done_sticky: got DONE left without restart, required sticky");
        else passed++;
        pulse_restart();
        total++;
        if (obs_done !== 1'b0 || obs_ready !== 1'b1)
            $display("FAIL done_restart: got done=%b ready=%b, required 0 1", obs_done, obs_ready);
        else
            passed++;
        send(8'h50, 0); send(8'h0F, 1);
        send(8'h50, 0); send(8'h90, 1);
        check_sb_empty("done_restart");
    endtask

    task automatic test_err_reset();
        bit held = 1'b1;
        sel = 1'b0;
        do_reset();
        send(8'h50, 0); send(8'hB0, 1);
        send(8'hA0, 0);
        for (int i = 0; i < 4; i++) begin
            if (obs_err !== 1'b1 || obs_ready !== 1'b0) held = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!held) $display("FAIL err_sticky: got err=%b ready=%b, required 1 0", obs_err, obs_ready);
        else passed++;
        pulse_restart();
        send(8'h61, 0); send(8'hFF, 0); send(8'hFF, 0);
        idle(5);
        total++;
        if (obs_busy !== 1'b1) $display("FAIL long_wait_busy: got %b, required 1", obs_busy);
        else passed++;
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        model_latch = 3'd0;
        #1;
        total++;
        if ({obs_reg, obs_val, obs_wr, obs_busy, obs_done, obs_err} !== 16'd0)
            $display("FAIL async_reset: got reg=%0d val=%02h wr=%b busy=%b done=%b err=%b, required all 0",
                     obs_reg, obs_val, obs_wr, obs_busy, obs_done, obs_err);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h50, 0); send(8'h85, 1);
        send(8'h50, 0);
        do_reset();
        send(8'h66, 0);
        total++;
        if (obs_done !== 1'b1) $display("FAIL reset_mid_arg: got done=%b, required 1", obs_done);
        else passed++;
        check_sb_empty("err_reset");
    endtask

    initial begin
        rst_n       = 1'b0;
        drv_data    = 8'h00;
        drv_valid   = 1'b0;
        drv_restart = 1'b0;
        sel         = 1'b0;
        model_latch = 3'd0;
        test_reset();
        test_writes();
        test_wait_cmd();
        test_long_waits();
        test_gapped();
        test_done_restart();
        test_err_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
